fetch_ctrl: RTL and testbench

//  Sequences instruction fetch: owns the fetch PC and drives the instruction bus,

---
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the fetch PC, issues at most one
// outstanding ibus request, and hands fetched words to decode through a
// one-entry buffer. Redirects flush the buffer and squash wrong-path data.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] PC_STEP  = 32'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_adel
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              r_inst_valid;
  logic [XLEN-1:0]   r_inst;
  logic [XLEN-1:0]   r_inst_pc;
  logic              r_inst_adel;

  logic              w_buf_free;
  logic              w_aligned;
  logic              w_ireq_valid;
  logic              w_load;
  logic [XLEN-1:0]   w_load_word;
  logic              w_load_adel;

  // Buffer can take a new entry if empty or being consumed on this edge.
  assign w_buf_free   = ~r_inst_valid | ~stall;
  assign w_aligned    = (r_pc[1:0] == 2'b00);
  assign w_ireq_valid = ~reset & (r_state == S_REQ) & ~redirect_valid & w_buf_free & w_aligned;

  assign ireq_valid = w_ireq_valid;
  assign ireq_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_adel  = r_inst_adel;

  // Next-state, next-PC and buffer-load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_load_word = '0;
    w_load_adel = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else if (w_ireq_valid && ireq_addr_ok) begin
          w_state_nxt = S_WAIT;
        end else if (!w_aligned && w_buf_free) begin
          w_load      = 1'b1;
          w_load_adel = 1'b1;
          w_state_nxt = S_ERR;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = iresp_data_ok ? S_REQ : S_DROP;
        end else if (iresp_data_ok) begin
          w_load      = 1'b1;
          w_load_word = iresp_data;
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        if (iresp_data_ok) w_state_nxt = S_REQ;
      end
      S_ERR: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Output buffer: flush beats load, load beats consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_adel  <= 1'b0;
    end else if (redirect_valid) begin
      r_inst_valid <= 1'b0;
    end else if (w_load) begin
      r_inst_valid <= 1'b1;
      r_inst       <= w_load_word;
      r_inst_pc    <= r_pc;
      r_inst_adel  <= w_load_adel;
    end else if (r_inst_valid && !stall) begin
      r_inst_valid <= 1'b0;
    end
  end

  // data_ok is only legal while a request is outstanding.
  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
    iresp_data_ok |-> (r_state == S_WAIT || r_state == S_DROP))
    else $error("iresp_data_ok with no outstanding request");

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: scripted vector table, reset-in-flight sequence, and a
// randomized run checked against a transaction-level model of the fetcher.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_adel;

  int n_chk;
  int n_fail;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_adel;
  } vec_t;

  localparam int unsigned NVEC = 31;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rp,
                              input logic ao, input logic dk, input logic [31:0] dt,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep, input logic ed);
    vec_t v;
    v.stall = st; v.redir = rd; v.rpc = rp; v.aok = ao; v.dok = dk; v.data = dt;
    v.e_req = er; v.e_addr = ea; v.e_iv = ev; v.e_inst = ei; v.e_ipc = ep; v.e_adel = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rp,
                       input logic ao, input logic dk, input logic [31:0] dt);
    stall = st; redirect_valid = rd; redirect_pc = rp;
    ireq_addr_ok = ao; iresp_data_ok = dk; iresp_data = dt;
  endtask

  // Reference model: fetch PC plus flags for "request in flight", "in-flight
  // response is wrong-path" and "parked on an address error".
  logic [31:0] m_pc;
  logic        m_out, m_wrong, m_err;
  logic        m_bv, m_adel;
  logic [31:0] m_inst, m_ipc;

  task automatic model_reset();
    m_pc = 32'hbfc00000; m_out = 0; m_wrong = 0; m_err = 0;
    m_bv = 0; m_adel = 0; m_inst = 0; m_ipc = 0;
  endtask

  function automatic logic model_req();
    logic free;
    free = !m_bv || !stall;
    return !m_out && !m_err && !redirect_valid && free && (m_pc % 4 == 0);
  endfunction

  task automatic model_step();
    logic free, req, got_word, trap;
    free     = !m_bv || !stall;
    req      = model_req();
    got_word = m_out && !m_wrong && iresp_data_ok && !redirect_valid;
    trap     = !m_out && !m_err && !redirect_valid && (m_pc % 4 != 0) && free;
    if (redirect_valid)         m_bv = 0;
    else if (got_word) begin    m_bv = 1; m_inst = iresp_data; m_ipc = m_pc; m_adel = 0; end
    else if (trap) begin        m_bv = 1; m_inst = 0; m_ipc = m_pc; m_adel = 1; end
    else if (m_bv && !stall)    m_bv = 0;
    if (trap) m_err = 1;
    else if (m_err && redirect_valid) m_err = 0;
    if (m_out) begin
      if (iresp_data_ok) begin m_out = 0; m_wrong = 0; end
      else if (redirect_valid) m_wrong = 1;
    end else if (req && ireq_addr_ok) begin
      m_out = 1; m_wrong = 0;
    end
    if (redirect_valid) m_pc = redirect_pc;
    else if (got_word)  m_pc = m_pc + 32'd4;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    //             st rd rpc           ao dk data          req addr          iv inst          ipc           adel
    tbl[0]  = mk(0, 0, 0,            1, 0, 0,            1, 32'hbfc00000, 0, 0,            0,            0);
    tbl[1]  = mk(0, 0, 0,            0, 1, 32'h24010001, 0, 32'hbfc00000, 0, 0,            0,            0);
    tbl[2]  = mk(1, 0, 0,            0, 0, 0,            0, 32'hbfc00004, 1, 32'h24010001, 32'hbfc00000, 0);
    tbl[3]  = mk(1, 0, 0,            0, 0, 0,            0, 32'hbfc00004, 1, 32'h24010001, 32'hbfc00000, 0);
    tbl[4]  = mk(1, 0, 0,            0, 0, 0,            0, 32'hbfc00004, 1, 32'h24010001, 32'hbfc00000, 0);
    tbl[5]  = mk(0, 0, 0,            1, 0, 0,            1, 32'hbfc00004, 1, 32'h24010001, 32'hbfc00000, 0);
    tbl[6]  = mk(0, 1, 32'h80000000, 0, 0, 0,            0, 32'hbfc00004, 0, 0,            0,            0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,            0, 32'h80000000, 0, 0,            0,            0);
    tbl[8]  = mk(0, 0, 0,            0, 1, 32'hdeadbeef, 0, 32'h80000000, 0, 0,            0,            0);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0,            1, 32'h80000000, 0, 0,            0,            0);
    tbl[10] = mk(0, 1, 32'h80000002, 0, 0, 0,            0, 32'h80000000, 0, 0,            0,            0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,            0, 32'h80000002, 0, 0,            0,            0);
    tbl[12] = mk(1, 0, 0,            0, 0, 0,            0, 32'h80000002, 1, 0,            32'h80000002, 1);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,            0, 32'h80000002, 1, 0,            32'h80000002, 1);
    tbl[14] = mk(0, 0, 0,            1, 0, 0,            0, 32'h80000002, 0, 0,            0,            0);
    tbl[15] = mk(0, 1, 32'h80000180, 0, 0, 0,            0, 32'h80000002, 0, 0,            0,            0);
    tbl[16] = mk(0, 0, 0,            1, 0, 0,            1, 32'h80000180, 0, 0,            0,            0);
    tbl[17] = mk(0, 1, 32'h80000100, 0, 1, 32'h11111111, 0, 32'h80000180, 0, 0,            0,            0);
    tbl[18] = mk(0, 0, 0,            1, 0, 0,            1, 32'h80000100, 0, 0,            0,            0);
    tbl[19] = mk(0, 1, 32'h80000200, 0, 0, 0,            0, 32'h80000100, 0, 0,            0,            0);
    tbl[20] = mk(0, 1, 32'h80000300, 0, 0, 0,            0, 32'h80000200, 0, 0,            0,            0);
    tbl[21] = mk(0, 0, 0,            0, 1, 32'h22222222, 0, 32'h80000300, 0, 0,            0,            0);
    tbl[22] = mk(0, 0, 0,            1, 0, 0,            1, 32'h80000300, 0, 0,            0,            0);
    tbl[23] = mk(0, 0, 0,            0, 1, 32'h33333333, 0, 32'h80000300, 0, 0,            0,            0);
    tbl[24] = mk(1, 0, 0,            0, 0, 0,            0, 32'h80000304, 1, 32'h33333333, 32'h80000300, 0);
    tbl[25] = mk(1, 1, 32'h80000400, 0, 0, 0,            0, 32'h80000304, 1, 32'h33333333, 32'h80000300, 0);
    tbl[26] = mk(1, 0, 0,            0, 0, 0,            1, 32'h80000400, 0, 0,            0,            0);
    tbl[27] = mk(0, 1, 32'hfffffffc, 0, 0, 0,            0, 32'h80000400, 0, 0,            0,            0);
    tbl[28] = mk(0, 0, 0,            1, 0, 0,            1, 32'hfffffffc, 0, 0,            0,            0);
    tbl[29] = mk(0, 0, 0,            0, 1, 32'h44444444, 0, 32'hfffffffc, 0, 0,            0,            0);
    tbl[30] = mk(0, 0, 0,            0, 0, 0,            1, 32'h00000000, 1, 32'h44444444, 32'hfffffffc, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ireq_valid", 32'(ireq_valid), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_adel", 32'(inst_adel), 0);
    chk("rst_ireq_addr", ireq_addr, 32'hbfc00000);

    // Scripted vectors
    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].aok, tbl[i].dok, tbl[i].data);
      #1;
      chk($sformatf("v%0d_ireq_valid", i), 32'(ireq_valid), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_ireq_addr", i), ireq_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
        chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
        chk($sformatf("v%0d_inst_adel", i), 32'(inst_adel), 32'(tbl[i].e_adel));
      end
    end

    // Reset while a request is outstanding
    @(negedge clk); drive(0, 0, 0, 1, 0, 0); #1;
    chk("rw_req", 32'(ireq_valid), 1);
    chk("rw_addr", ireq_addr, 32'h00000000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); reset = 1'b1; #1;
    chk("rw_req_in_reset", 32'(ireq_valid), 0);
    @(negedge clk); #1;
    chk("rw_iv", 32'(inst_valid), 0);
    chk("rw_inst", inst, 0);
    chk("rw_ipc", inst_pc, 0);
    chk("rw_adel", 32'(inst_adel), 0);
    chk("rw_addr_rst", ireq_addr, 32'hbfc00000);
    @(negedge clk); reset = 1'b0; #1;
    chk("rw_first_req", 32'(ireq_valid), 1);
    chk("rw_first_addr", ireq_addr, 32'hbfc00000);

    // Randomized run against the model
    @(negedge clk); reset = 1'b1; drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic        r_st, r_rd, r_ao, r_dk;
      logic [31:0] r_pc;
      @(negedge clk);
      reset = 1'b0;
      r_st = ($urandom_range(0, 2) == 0);
      r_rd = ($urandom_range(0, 7) == 0);
      r_pc = $urandom;
      if ($urandom_range(0, 7) != 0) r_pc[1:0] = 2'b00;
      r_ao = ($urandom_range(0, 1) == 1);
      r_dk = m_out && ($urandom_range(0, 1) == 1);
      drive(r_st, r_rd, r_pc, r_ao, r_dk, $urandom);
      #1;
      chk("rnd_ireq_valid", 32'(ireq_valid), 32'(model_req()));
      chk("rnd_ireq_addr", ireq_addr, m_pc);
      chk("rnd_inst_valid", 32'(inst_valid), 32'(m_bv));
      if (m_bv) begin
        chk("rnd_inst", inst, m_inst);
        chk("rnd_inst_pc", inst_pc, m_ipc);
        chk("rnd_inst_adel", 32'(inst_adel), 32'(m_adel));
      end
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
